axis_rr_arbiter: RTL and testbench

Two-input, packet-granular round-robin arbiter that shares the single 8-bit AXI-stream byte datapath (m00 output toward the ALU/UART path) between two AXI-stream requesters. A grant is held from the first beat until the beat carrying tlast is accepted, so packets never interleave. The output passes through a one-deep register stage. tuser is stamped with the source index and the byte position within the packet. Per-source packet counters are exposed for debug/LED display.

---
 rtl/axis_arb_pkg.sv | 19 +
 rtl/axis_out_reg.sv | 50 +++++
 rtl/axis_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_axis_rr_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the two-input AXI-stream round-robin arbiter.
package axis_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_e;

   localparam logic SRC_S00 = 1'b0;
   localparam logic SRC_S01 = 1'b1;

   // Increment that sticks at max_val instead of wrapping back to zero.
   function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                           input logic [31:0] max_val);
      return (val >= max_val) ? max_val : val + 32'd1;
   endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-deep AXI-stream register slice; load and drain can happen in the same
// cycle, so a continuous stream passes at one beat per clock.
module axis_out_reg #(
   parameter int DATA_WIDTH = 8,
   parameter int USER_WIDTH = 12
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   input  logic [USER_WIDTH-1:0] in_user,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic [USER_WIDTH-1:0] out_user,
   input  logic                  out_ready
);

   logic                  vld_p1;
   logic [DATA_WIDTH-1:0] data_p1;
   logic                  last_p1;
   logic [USER_WIDTH-1:0] user_p1;

   assign in_ready = !vld_p1 || out_ready;

   // Stage p1: output holding register
   always_ff @(posedge aclk) begin
      if (areset) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         last_p1 <= 1'b0;
         user_p1 <= '0;
      end else if (in_valid && in_ready) begin
         vld_p1  <= 1'b1;
         data_p1 <= in_data;
         last_p1 <= in_last;
         user_p1 <= in_user;
      end else if (out_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   assign out_valid = vld_p1;
   assign out_data  = data_p1;
   assign out_last  = last_p1;
   assign out_user  = user_p1;

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one byte stream between two
// requesters; beats are tagged with {source, byte index} in tuser.
module axis_rr_arbiter
   import axis_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int USER_WIDTH = 12,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  s00_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
   input  logic                  s00_axis_tlast,
   output logic                  s00_axis_tready,
   input  logic                  s01_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s01_axis_tdata,
   input  logic                  s01_axis_tlast,
   output logic                  s01_axis_tready,
   output logic                  m00_axis_tvalid,
   output logic [DATA_WIDTH-1:0] m00_axis_tdata,
   output logic                  m00_axis_tlast,
   output logic [USER_WIDTH-1:0] m00_axis_tuser,
   input  logic                  m00_axis_tready,
   output logic [CNT_WIDTH-1:0]  pkt_cnt0,
   output logic [CNT_WIDTH-1:0]  pkt_cnt1
);

   localparam int               IDX_W   = USER_WIDTH - 1;
   localparam logic [IDX_W-1:0] IDX_MAX = '1;

   state_e                  state, state_nxt;
   logic                    last_grant;
   logic [IDX_W-1:0]        byte_idx;
   logic [CNT_WIDTH-1:0]    cnt0, cnt1;

   logic                    sel_valid;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic                    sel_last;
   logic                    sel_src;
   logic [USER_WIDTH-1:0]   sel_user;
   logic                    slot_ready;
   logic                    accept;

   always_ff @(posedge aclk) begin
      if (areset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (s00_axis_tvalid && s01_axis_tvalid)
               state_nxt = (last_grant == SRC_S00) ? GRANT1 : GRANT0;
            else if (s00_axis_tvalid)
               state_nxt = GRANT0;
            else if (s01_axis_tvalid)
               state_nxt = GRANT1;
         end
         GRANT0, GRANT1: begin
            if (accept && sel_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Grant steers the owner onto the shared slot; nobody is ready in IDLE.
   always_comb begin
      sel_valid       = 1'b0;
      sel_data        = '0;
      sel_last        = 1'b0;
      sel_src         = SRC_S00;
      s00_axis_tready = 1'b0;
      s01_axis_tready = 1'b0;
      case (state)
         GRANT0: begin
            sel_valid       = s00_axis_tvalid;
            sel_data        = s00_axis_tdata;
            sel_last        = s00_axis_tlast;
            sel_src         = SRC_S00;
            s00_axis_tready = slot_ready;
         end
         GRANT1: begin
            sel_valid       = s01_axis_tvalid;
            sel_data        = s01_axis_tdata;
            sel_last        = s01_axis_tlast;
            sel_src         = SRC_S01;
            s01_axis_tready = slot_ready;
         end
         default: ;
      endcase
   end

   assign accept   = sel_valid && slot_ready;
   assign sel_user = {sel_src, byte_idx};

   always_ff @(posedge aclk) begin
      if (areset) begin
         last_grant <= SRC_S01;
         byte_idx   <= '0;
         cnt0       <= '0;
         cnt1       <= '0;
      end else if (accept) begin
         if (sel_last) begin
            byte_idx   <= '0;
            last_grant <= sel_src;
            if (sel_src == SRC_S01) cnt1 <= cnt1 + 1'b1;
            else                    cnt0 <= cnt0 + 1'b1;
         end else begin
            byte_idx <= IDX_W'(sat_inc(32'(byte_idx), 32'(IDX_MAX)));
         end
      end
   end

   assign pkt_cnt0 = cnt0;
   assign pkt_cnt1 = cnt1;

   axis_out_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .USER_WIDTH (USER_WIDTH)
   ) u_out_reg (
      .aclk      (aclk),
      .areset    (areset),
      .in_valid  (sel_valid),
      .in_data   (sel_data),
      .in_last   (sel_last),
      .in_user   (sel_user),
      .in_ready  (slot_ready),
      .out_valid (m00_axis_tvalid),
      .out_data  (m00_axis_tdata),
      .out_last  (m00_axis_tlast),
      .out_user  (m00_axis_tuser),
      .out_ready (m00_axis_tready)
   );

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: per-source expected-beat queues filled
// by the drivers and drained by a monitor on the m00 handshake.
module tb_axis_rr_arbiter;

   localparam int DW = 8;
   localparam int UW = 12;
   localparam int CW = 16;

   logic          aclk;
   logic          areset;
   logic          s00_tvalid, s00_tlast, s00_tready;
   logic [DW-1:0] s00_tdata;
   logic          s01_tvalid, s01_tlast, s01_tready;
   logic [DW-1:0] s01_tdata;
   logic          m00_tvalid, m00_tlast, m00_tready;
   logic [DW-1:0] m00_tdata;
   logic [UW-1:0] m00_tuser;
   logic [CW-1:0] pkt_cnt0, pkt_cnt1;

   axis_rr_arbiter #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .CNT_WIDTH(CW)) dut (
      .aclk            (aclk),
      .areset          (areset),
      .s00_axis_tvalid (s00_tvalid),
      .s00_axis_tdata  (s00_tdata),
      .s00_axis_tlast  (s00_tlast),
      .s00_axis_tready (s00_tready),
      .s01_axis_tvalid (s01_tvalid),
      .s01_axis_tdata  (s01_tdata),
      .s01_axis_tlast  (s01_tlast),
      .s01_axis_tready (s01_tready),
      .m00_axis_tvalid (m00_tvalid),
      .m00_axis_tdata  (m00_tdata),
      .m00_axis_tlast  (m00_tlast),
      .m00_axis_tuser  (m00_tuser),
      .m00_axis_tready (m00_tready),
      .pkt_cnt0        (pkt_cnt0),
      .pkt_cnt1        (pkt_cnt1)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   // Scoreboard entries are {tlast, tuser, tdata}.
   logic [20:0] exp_q0[$];
   logic [20:0] exp_q1[$];
   logic        src_order_q[$];
   int          cnt_exp[2];
   int          beats_acc[2];

   bit          in_pkt;
   logic        cur_src;
   bit          held;
   logic [20:0] held_val;
   logic [20:0] mon_got;
   logic [20:0] mon_want;
   logic        mon_src;

   always @(negedge aclk) begin
      mon_got = {m00_tlast, m00_tuser, m00_tdata};
      if (held) begin
         check("hold_valid", 32'(m00_tvalid), 32'd1);
         check("hold_beat", 32'(mon_got), 32'(held_val));
      end
      held = 1'b0;
      if (m00_tvalid && !m00_tready) begin
         held     = 1'b1;
         held_val = mon_got;
         check("stall_s00_rdy", 32'(s00_tready), 32'd0);
         check("stall_s01_rdy", 32'(s01_tready), 32'd0);
      end
      if (m00_tvalid && m00_tready) begin
         mon_src = m00_tuser[UW-1];
         if (in_pkt) check("no_interleave", 32'(mon_src), 32'(cur_src));
         if (mon_src == 1'b0) begin
            if (exp_q0.size() == 0) check("unexpected_s00_beat", 32'(mon_got), 32'h1FFFFF);
            else begin
               mon_want = exp_q0.pop_front();
               check("beat_s00", 32'(mon_got), 32'(mon_want));
            end
         end else begin
            if (exp_q1.size() == 0) check("unexpected_s01_beat", 32'(mon_got), 32'h1FFFFF);
            else begin
               mon_want = exp_q1.pop_front();
               check("beat_s01", 32'(mon_got), 32'(mon_want));
            end
         end
         in_pkt  = !m00_tlast;
         cur_src = mon_src;
         if (m00_tlast) src_order_q.push_back(mon_src);
      end
      if (areset) begin
         in_pkt = 1'b0;
         held   = 1'b0;
      end
   end

   task automatic send_pkt(input int src, input int nbeats, input logic [7:0] base, input int gap);
      logic [7:0]  d;
      logic        l;
      logic [10:0] idx;
      bit          ok;
      for (int i = 0; i < nbeats; i++) begin
         d   = base + 8'(i);
         l   = (i == nbeats - 1);
         idx = (i < 2047) ? 11'(i) : 11'd2047;
         if (src == 0) begin
            exp_q0.push_back({l, 1'b0, idx, d});
            s00_tvalid = 1'b1; s00_tdata = d; s00_tlast = l;
         end else begin
            exp_q1.push_back({l, 1'b1, idx, d});
            s01_tvalid = 1'b1; s01_tdata = d; s01_tlast = l;
         end
         ok = 1'b0;
         for (int k = 0; k < 200; k++) begin
            @(negedge aclk);
            if ((src == 0) ? s00_tready : s01_tready) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) begin
            check("accept_timeout", 32'(src), 32'hFFFF);
            if (src == 0) s00_tvalid = 1'b0; else s01_tvalid = 1'b0;
            return;
         end
         @(posedge aclk); #1;
         check("lat_valid", 32'(m00_tvalid), 32'd1);
         check("lat_beat", 32'({m00_tlast, m00_tuser, m00_tdata}), 32'({l, src[0], idx, d}));
         beats_acc[src]++;
         if (l) cnt_exp[src]++;
         if (src == 0) s00_tvalid = 1'b0; else s01_tvalid = 1'b0;
         if (i == 0 && gap > 0) begin
            repeat (gap) @(posedge aclk);
            #1;
         end
      end
   endtask

   task automatic drain();
      repeat (3) @(posedge aclk);
      #1;
   endtask

   task automatic check_order(input string tag, input int n, input logic [3:0] pattern);
      check({tag, "_count"}, 32'(src_order_q.size()), 32'(n));
      for (int i = 0; i < n; i++)
         if (i < src_order_q.size()) check({tag, "_src"}, 32'(src_order_q[i]), 32'(pattern[i]));
   endtask

   int          b0;
   logic [20:0] rst_beat;
   bit          rst_ok;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      areset = 1'b1;
      s00_tvalid = 1'b0; s00_tdata = '0; s00_tlast = 1'b0;
      s01_tvalid = 1'b0; s01_tdata = '0; s01_tlast = 1'b0;
      m00_tready = 1'b1;
      cnt_exp = '{0, 0};
      beats_acc = '{0, 0};
      repeat (3) @(posedge aclk);
      #1;
      check("rst_m00_tvalid", 32'(m00_tvalid), 32'd0);
      check("rst_m00_tdata", 32'(m00_tdata), 32'd0);
      check("rst_m00_tlast", 32'(m00_tlast), 32'd0);
      check("rst_m00_tuser", 32'(m00_tuser), 32'd0);
      check("rst_pkt_cnt0", 32'(pkt_cnt0), 32'd0);
      check("rst_pkt_cnt1", 32'(pkt_cnt1), 32'd0);
      check("rst_s00_tready", 32'(s00_tready), 32'd0);
      check("rst_s01_tready", 32'(s01_tready), 32'd0);
      areset = 1'b0;

      // Contention from reset: s00 wins first, then strict alternation.
      src_order_q.delete();
      fork
         begin send_pkt(0, 2, 8'h10, 0); send_pkt(0, 2, 8'h30, 0); end
         begin send_pkt(1, 2, 8'h20, 0); send_pkt(1, 2, 8'h40, 0); end
      join
      drain();
      check_order("contention", 4, 4'b1010);

      // Single source, three beats.
      send_pkt(0, 3, 8'hA1, 0);
      drain();
      check("single_pkt_cnt0", 32'(pkt_cnt0), 32'(cnt_exp[0]));
      check("single_pkt_cnt1", 32'(pkt_cnt1), 32'(cnt_exp[1]));

      // Downstream backpressure mid-packet.
      fork
         send_pkt(0, 6, 8'hB0, 0);
         begin
            repeat (3) @(posedge aclk);
            #1 m00_tready = 1'b0;
            repeat (4) @(posedge aclk);
            #1 m00_tready = 1'b1;
         end
      join
      drain();
      check("bp_pkt_cnt0", 32'(pkt_cnt0), 32'(cnt_exp[0]));

      // Owner stalls after its first beat; the other source must stay blocked.
      src_order_q.delete();
      b0 = beats_acc[0];
      fork
         send_pkt(0, 3, 8'hC0, 10);
         begin
            for (int k = 0; k < 50; k++) begin
               @(posedge aclk); #2;
               if (beats_acc[0] != b0) break;
            end
            fork
               send_pkt(1, 2, 8'hD0, 0);
               begin
                  for (int k = 0; k < 8; k++) begin
                     @(negedge aclk);
                     check("owner_hold_s01_rdy", 32'(s01_tready), 32'd0);
                  end
               end
            join
         end
      join
      drain();
      check_order("stalled_owner", 2, 4'b0010);

      // Long packet: byte index saturates at 0x7FF.
      send_pkt(1, 2100, 8'h00, 0);
      drain();
      check("sat_pkt_cnt1", 32'(pkt_cnt1), 32'(cnt_exp[1]));

      // Single-beat packet.
      send_pkt(0, 1, 8'hE5, 0);
      drain();
      check("one_beat_pkt_cnt0", 32'(pkt_cnt0), 32'(cnt_exp[0]));

      // Reset while beat 2 of an s00 packet is presented.
      rst_beat = {1'b0, 12'h000, 8'h51};
      exp_q0.push_back(rst_beat);
      s00_tvalid = 1'b1; s00_tdata = 8'h51; s00_tlast = 1'b0;
      rst_ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge aclk);
         if (s00_tready) begin rst_ok = 1'b1; break; end
      end
      check("rst_seq_accept", 32'(rst_ok), 32'd1);
      @(posedge aclk); #1;
      s00_tdata = 8'h52;
      areset = 1'b1;
      @(posedge aclk); #1;
      areset = 1'b0;
      s00_tvalid = 1'b0;
      cnt_exp = '{0, 0};
      check("midrst_m00_tvalid", 32'(m00_tvalid), 32'd0);
      check("midrst_pkt_cnt0", 32'(pkt_cnt0), 32'd0);
      check("midrst_pkt_cnt1", 32'(pkt_cnt1), 32'd0);
      check("midrst_s00_tready", 32'(s00_tready), 32'd0);
      check("midrst_s01_tready", 32'(s01_tready), 32'd0);
      check("midrst_q0_left", 32'(exp_q0.size()), 32'd0);

      // After reset s00 wins again even though it owned the last packet.
      src_order_q.delete();
      fork
         send_pkt(0, 1, 8'h61, 0);
         send_pkt(1, 1, 8'h62, 0);
      join
      drain();
      check_order("post_reset", 2, 4'b0010);

      check("final_pkt_cnt0", 32'(pkt_cnt0), 32'(cnt_exp[0]));
      check("final_pkt_cnt1", 32'(pkt_cnt1), 32'(cnt_exp[1]));
      check("final_q0_left", 32'(exp_q0.size()), 32'd0);
      check("final_q1_left", 32'(exp_q1.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
